// File: rtl/battle_if.sv
// Battle-screen bus: scan position, keyboard and attack-bar/collision inputs in,
// turn state and score registers out. The sequencer is the master.
interface battle_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [15:0] key;
  logic        space_pressed;
  logic [9:0]  damage;
  logic        player_hit;
  logic [3:0]  state;
  logic [9:0]  enemy_hp;
  logic [9:0]  player_hp;
  logic [9:0]  last_dmg;
  logic [7:0]  turn_count;

  modport master (
    input  x, y, key, space_pressed, damage, player_hit,
    output state, enemy_hp, player_hp, last_dmg, turn_count
  );

  modport slave (
    output x, y, key, space_pressed, damage, player_hit,
    input  state, enemy_hp, player_hp, last_dmg, turn_count
  );
endinterface

// File: rtl/battle_sequencer.sv
// Turn-level battle controller: TITLE->MENU->ATTACK->RESULT->DODGE->MENU until WIN/LOSE.
// Optional HEAL menu action is enabled by defining BATTLE_HEAL_EN.
module battle_sequencer #(
  parameter int unsigned ENEMY_HP_INIT  = 100,
  parameter int unsigned PLAYER_HP_INIT = 20,
  parameter int unsigned DMG_SHIFT      = 3,
  parameter int unsigned HIT_DMG        = 1,
  parameter int unsigned ATTACK_FRAMES  = 240,
  parameter int unsigned RESULT_FRAMES  = 60,
  parameter int unsigned DODGE_FRAMES   = 300,
  parameter int unsigned HEAL_AMT       = 5
) (
  input logic      clk,
  input logic      reset,
  battle_if.master bus
);

  typedef enum logic [3:0] {
    S_TITLE  = 4'd0,
    S_MENU   = 4'd1,
    S_ATTACK = 4'd2,
    S_RESULT = 4'd3,
    S_DODGE  = 4'd4,
    S_WIN    = 4'd5,
    S_LOSE   = 4'd6
  } state_t;

  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  state_t      state_q, state_d;
  logic [9:0]  enemy_hp_q, enemy_hp_d;
  logic [9:0]  player_hp_q, player_hp_d;
  logic [9:0]  last_dmg_q, last_dmg_d;
  logic [7:0]  turn_q, turn_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        hit_flag_q, hit_flag_d;
  logic        enter_q, space_q, press_q;

  logic        frame_tick;
  logic        enter_mk, space_mk;
  logic        enter_ev, space_ev, hit_ev;
  logic        hit_now;
  logic [9:0]  atk_dmg;
  logic [9:0]  php_after_hit;

  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : 10'd0;
  endfunction

  assign frame_tick = (bus.x == 10'd639) && (bus.y == 10'd479);
  assign enter_mk   = (bus.key[7:0] == CODE_ENTER) && (bus.key[15:8] != CODE_BREAK);
  assign space_mk   = (bus.key[7:0] == CODE_SPACE) && (bus.key[15:8] != CODE_BREAK);
  assign enter_ev   = enter_mk & ~enter_q;
  assign space_ev   = space_mk & ~space_q;
  assign hit_ev     = bus.space_pressed & ~press_q;
  assign atk_dmg    = bus.damage >> DMG_SHIFT;
  assign hit_now    = hit_flag_q | bus.player_hit;
  assign php_after_hit = hit_now ? sat_sub(player_hp_q, 10'(HIT_DMG)) : player_hp_q;

`ifdef BATTLE_HEAL_EN
  localparam logic [7:0] CODE_HEAL = 8'h33;
  logic        heal_mk, heal_ev, heal_q;
  logic [10:0] heal_sum;
  logic [9:0]  healed_hp;

  assign heal_mk   = (bus.key[7:0] == CODE_HEAL) && (bus.key[15:8] != CODE_BREAK);
  assign heal_ev   = heal_mk & ~heal_q;
  assign heal_sum  = {1'b0, player_hp_q} + 11'(HEAL_AMT);
  assign healed_hp = (heal_sum > 11'(PLAYER_HP_INIT)) ? 10'(PLAYER_HP_INIT) : heal_sum[9:0];

  always_ff @(posedge clk) begin
    if (reset) heal_q <= 1'b0;
    else       heal_q <= heal_mk;
  end
`endif

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    enemy_hp_d  = enemy_hp_q;
    player_hp_d = player_hp_q;
    last_dmg_d  = last_dmg_q;
    turn_d      = turn_q;
    hit_flag_d  = 1'b0;

    unique case (state_q)
      S_TITLE: if (enter_ev) state_d = S_MENU;

      S_MENU: begin
        if (space_ev) begin
          state_d = S_ATTACK;
`ifdef BATTLE_HEAL_EN
        end else if (heal_ev) begin
          player_hp_d = healed_hp;
          last_dmg_d  = 10'd0;
          state_d     = S_DODGE;
`endif
        end
      end

      // A hit landing on the timeout tick still counts.
      S_ATTACK: begin
        if (hit_ev) begin
          last_dmg_d = atk_dmg;
          enemy_hp_d = sat_sub(enemy_hp_q, atk_dmg);
          state_d    = S_RESULT;
        end else if (frame_tick && frame_cnt_q == 16'(ATTACK_FRAMES - 1)) begin
          last_dmg_d = 10'd0;
          state_d    = S_RESULT;
        end
      end

      S_RESULT: begin
        if (frame_tick && frame_cnt_q == 16'(RESULT_FRAMES - 1))
          state_d = (enemy_hp_q == 10'd0) ? S_WIN : S_DODGE;
      end

      // Collisions accumulate into one flag per frame; damage lands before the end-of-turn check.
      S_DODGE: begin
        if (frame_tick) begin
          player_hp_d = php_after_hit;
          if (php_after_hit == 10'd0) begin
            state_d = S_LOSE;
          end else if (frame_cnt_q == 16'(DODGE_FRAMES - 1)) begin
            state_d = S_MENU;
            turn_d  = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
          end
        end else begin
          hit_flag_d = hit_now;
        end
      end

      S_WIN, S_LOSE: begin
        if (enter_ev) begin
          state_d     = S_TITLE;
          enemy_hp_d  = 10'(ENEMY_HP_INIT);
          player_hp_d = 10'(PLAYER_HP_INIT);
          last_dmg_d  = 10'd0;
          turn_d      = 8'd0;
        end
      end

      default: state_d = S_TITLE;
    endcase

    if (state_d != state_q)  frame_cnt_d = 16'd0;
    else if (frame_tick)     frame_cnt_d = frame_cnt_q + 16'd1;
    else                     frame_cnt_d = frame_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_TITLE;
      enemy_hp_q  <= 10'(ENEMY_HP_INIT);
      player_hp_q <= 10'(PLAYER_HP_INIT);
      last_dmg_q  <= 10'd0;
      turn_q      <= 8'd0;
      frame_cnt_q <= 16'd0;
      hit_flag_q  <= 1'b0;
      enter_q     <= 1'b0;
      space_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      enemy_hp_q  <= enemy_hp_d;
      player_hp_q <= player_hp_d;
      last_dmg_q  <= last_dmg_d;
      turn_q      <= turn_d;
      frame_cnt_q <= frame_cnt_d;
      hit_flag_q  <= hit_flag_d;
      enter_q     <= enter_mk;
      space_q     <= space_mk;
      press_q     <= bus.space_pressed;
    end
  end

  assign bus.state      = state_q;
  assign bus.enemy_hp   = enemy_hp_q;
  assign bus.player_hp  = player_hp_q;
  assign bus.last_dmg   = last_dmg_q;
  assign bus.turn_count = turn_q;

endmodule
